sum_accumulator: RTL and testbench
==================================

# sum_accumulator

Downstream consumer of the registered ripple-carry adder stage. Takes each registered `{cout, sum}` result as an unsigned (IN_W+1)-bit sample and accumulates BLOCK_LEN samples into a saturating ACC_W-bit total. It presents the block total on a valid/ready output handshake and back-pressures the producer while the total is waiting to be taken.

## Interface
- IN_W, 4: width of the adder sum input; sample width is IN_W+1.
- ACC_W, 6: accumulator width; saturates at 2^ACC_W-1.
- BLOCK_LEN, 4: samples per block, 2..255.

- clk  in  1  rising-edge clock, the only clock.
- rst  in  1  synchronous, active-high reset.
- clr  in  1  synchronous block abort/clear.
- in_valid  in  1  sample present on sum_in/cout_in.
- in_ready  out  1  block accepts a sample this cycle.
- sum_in  in  IN_W  adder sum_out.
- cout_in  in  1  adder cout_out, MSB of the sample.
- acc_out  out  ACC_W  running or final total.
- ovf  out  1  sticky saturation flag for the current block.
- out_valid  out  1  acc_out holds a completed block total.
- out_ready  in  1  downstream takes the total.

## Operation
- Sample value is {cout_in, sum_in}, zero-extended to ACC_W+1 bits before the add.
- The FSM has two states: ACCUM and HOLD.
- ACCUM behaviour:
  - in_ready=1 and out_valid=0.
  - A sample is accepted when in_valid && in_ready.
  - On accept: acc <= sat(acc + sample) and cnt <= cnt + 1.
  - On the accept where cnt == BLOCK_LEN-1: go to HOLD and set cnt <= 0.
- HOLD behaviour:
  - in_ready=0, out_valid=1, and acc_out and ovf are frozen.
  - in_valid is ignored.
  - When out_ready: acc <= 0, ovf <= 0, go to ACCUM.
- Saturation:
  - If the unclamped sum exceeds 2^ACC_W-1, acc <= 2^ACC_W-1 and ovf <= 1.
  - ovf stays set until the block completes its handshake, or until clr or rst.
- acc_out always shows the accumulator register. Its value is meaningful to downstream only while out_valid=1.
- Priority: rst > clr > handshake/accept.
  - clr in any state: acc=0, cnt=0, ovf=0, state=ACCUM. A pending total is discarded and out_ready is ignored that cycle.
  - The sample present on a clr cycle is dropped.

## Timing
- Reset values: acc_out=0, ovf=0, out_valid=0, in_ready=1, cnt=0, state=ACCUM.
- in_ready and out_valid are decoded from the state register only. There is no combinational path from in_valid or out_ready.
- acc_out updates on the clock edge after each accepted sample.
- out_valid rises on the edge after the BLOCK_LEN-th accepted sample (latency 1 cycle).
- In HOLD with out_ready=1, the next edge gives out_valid=0, in_ready=1, acc_out=0. Minimum sustained cadence is BLOCK_LEN+1 cycles per block.
- rst or clr mid-block or mid-HOLD takes effect on the same edge; the next cycle is clean ACCUM.
- cnt wrap: cnt never exceeds BLOCK_LEN-1. Its width is clog2(BLOCK_LEN).
- Samples arrive at most one per cycle, straight from the adder's registered outputs.

## Structure
- Shared package holds:
  - the state enum (ACCUM=1'b0, HOLD=1'b1);
  - default width constants IN_W_DEF=4 and ACC_W_DEF=6, shared with the adder stage;
  - a saturating max-value function.
- One sub-module, `sat_add`:
  - ACC_W-bit accumulator input, (IN_W+1)-bit sample input;
  - outputs the clamped sum and a sat flag;
  - purely combinational.
- FSM, counter and registers live in sum_accumulator.

## Test plan
- Reset: assert rst for 2 cycles. Then require acc_out=0, ovf=0, out_valid=0, in_ready=1.
- Normal block: feed samples {0,1010}=10, {1,1001}=25, {0,0001}=1, {0,0011}=3 back-to-back. Next cycle require acc_out=39 (6'h27), out_valid=1, ovf=0, in_ready=0.
- Backpressure:
  - Hold out_ready=0 for 5 cycles while in_valid=1 with varying data. Require acc_out=39 held, in_ready=0, and no samples counted.
  - Then raise out_ready. Next cycle require out_valid=0, acc_out=0, in_ready=1.
- Saturation: feed four samples of {1,1111}=31. After the 2nd sample require acc_out=62, ovf=0. After the 3rd require acc_out=63, ovf=1. The final total must be 63 with ovf=1.
- Clear mid-block: accept 2 samples of 7, then pulse clr together with in_valid=1. Require acc_out=0 and that sample dropped. Then four samples of 5 give out_valid with acc_out=20.
- Reset in HOLD: complete a block, then assert rst while out_valid=1 and out_ready=0. Next cycle require out_valid=0, in_ready=1, acc_out=0, ovf=0.

Source files
------------

// File: rtl/sum_accumulator_pkg.sv
// Shared definitions for the adder stage and the block accumulator behind it.
package sum_accumulator_pkg;

  // Block accumulator state: collecting samples, or holding a finished total.
  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } acc_state_e;

  // Default widths, shared with the registered ripple-carry adder stage.
  localparam int IN_W_DEF  = 4;
  localparam int ACC_W_DEF = 6;

  // Largest value representable in an unsigned field of the given width.
  function automatic logic [31:0] sat_max(input int width);
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/sum_accumulator_sat_add.sv
// Combinational saturating adder: accumulator plus one (IN_W+1)-bit sample,
// clamped at the accumulator's all-ones value.
module sat_add
  import sum_accumulator_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [IN_W:0]    sample,
  output logic [ACC_W-1:0] sum,
  output logic             sat
);

  // One guard bit above the accumulator is enough to see any overflow,
  // as long as the sample is no wider than the accumulator.
  localparam int SUM_W = ACC_W + 1;
  localparam logic [SUM_W-1:0] MAX_VAL = SUM_W'(sat_max(ACC_W));

  logic [SUM_W-1:0] raw_s;

  // Widen both operands, add, and clamp if the result exceeds the maximum.
  always_comb begin
    raw_s = SUM_W'(acc) + SUM_W'(sample);
    if (raw_s > MAX_VAL) begin
      sum = MAX_VAL[ACC_W-1:0];
      sat = 1'b1;
    end else begin
      sum = raw_s[ACC_W-1:0];
      sat = 1'b0;
    end
  end

endmodule

// File: rtl/sum_accumulator.sv
// Block accumulator: sums BLOCK_LEN adder results into a saturating total and
// offers the total on a valid/ready handshake, stalling the producer meanwhile.
module sum_accumulator
  import sum_accumulator_pkg::*;
#(
  parameter int IN_W      = IN_W_DEF,
  parameter int ACC_W     = ACC_W_DEF,
  parameter int BLOCK_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  sum_in,
  input  logic             cout_in,
  output logic [ACC_W-1:0] acc_out,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int CNT_W = $clog2(BLOCK_LEN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLOCK_LEN - 1);

  acc_state_e       state_r;
  acc_state_e       state_nxt_s;
  logic [ACC_W-1:0] acc_r;
  logic [ACC_W-1:0] sum_s;
  logic [CNT_W-1:0] cnt_r;
  logic             ovf_r;
  logic             sat_s;
  logic             accept_s;
  logic             last_s;

  sat_add #(
    .IN_W  (IN_W),
    .ACC_W (ACC_W)
  ) u_sat_add (
    .acc    (acc_r),
    .sample ({cout_in, sum_in}),
    .sum    (sum_s),
    .sat    (sat_s)
  );

  // in_ready comes from the state register only, so accept has no path from out_ready.
  assign accept_s = in_valid && in_ready;
  assign last_s   = (cnt_r == LAST_CNT);
  assign acc_out  = acc_r;
  assign ovf      = ovf_r;

  // State register; rst and clr both return to collecting.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ACCUM;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state: the final sample of a block enters HOLD, a taken total leaves it.
  always_comb begin
    state_nxt_s = state_r;
    if (clr) begin
      state_nxt_s = ACCUM;
    end else begin
      case (state_r)
        ACCUM: begin
          if (accept_s && last_s) begin
            state_nxt_s = HOLD;
          end else begin
            state_nxt_s = ACCUM;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_nxt_s = ACCUM;
          end else begin
            state_nxt_s = HOLD;
          end
        end
        default: state_nxt_s = ACCUM;
      endcase
    end
  end

  // Handshake outputs decoded purely from the current state.
  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    case (state_r)
      ACCUM: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
      end
      HOLD: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
      end
      default: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
      end
    endcase
  end

  // Datapath: accumulate accepted samples, freeze in HOLD, clear once the total is taken.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc_r <= '0;
      cnt_r <= '0;
      ovf_r <= 1'b0;
    end else if (state_r == HOLD) begin
      if (out_ready) begin
        acc_r <= '0;
        ovf_r <= 1'b0;
      end
    end else if (accept_s) begin
      acc_r <= sum_s;
      ovf_r <= ovf_r | sat_s;
      cnt_r <= last_s ? '0 : cnt_r + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_sum_accumulator.sv
// Randomised scoreboard bench for sum_accumulator with a block-level reference model.
module tb_sum_accumulator;

  localparam int IN_W    = 4;
  localparam int ACC_W   = 6;
  localparam int BL      = 4;
  localparam int SMP_W   = IN_W + 1;
  localparam int ACC_MAX = (1 << ACC_W) - 1;

  typedef struct {
    int acc;
    bit ovf;
  } exp_t;

  logic             clk;
  logic             rst;
  logic             clr;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  sum_in;
  logic             cout_in;
  logic [ACC_W-1:0] acc_out;
  logic             ovf;
  logic             out_valid;
  logic             out_ready;

  int   total_cnt = 0;
  int   bad_cnt   = 0;
  bit   chk_en    = 1'b0;
  exp_t exp_q[$];

  // Reference model: the samples of the current block and whether a total is held.
  int   m_blk[$];
  bit   m_hold = 1'b0;

  sum_accumulator #(
    .IN_W      (IN_W),
    .ACC_W     (ACC_W),
    .BLOCK_LEN (BL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum_in    (sum_in),
    .cout_in   (cout_in),
    .acc_out   (acc_out),
    .ovf       (ovf),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act != exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int blk_sum();
    int s = 0;
    foreach (m_blk[i]) s += m_blk[i];
    return s;
  endfunction

  function automatic int m_acc();
    int s = blk_sum();
    return (s > ACC_MAX) ? ACC_MAX : s;
  endfunction

  function automatic int m_ovf();
    return (blk_sum() > ACC_MAX) ? 1 : 0;
  endfunction

  // One clock cycle: drive inputs, check outputs mid-cycle against the model,
  // then advance the model by what the coming edge should do.
  task automatic step(input bit v, input logic [SMP_W-1:0] s, input bit ordy,
                      input bit c, input bit r);
    exp_t e;
    in_valid  = v;
    {cout_in, sum_in} = s;
    out_ready = ordy;
    clr       = c;
    rst       = r;
    @(negedge clk);
    if (chk_en) begin
      chk("in_ready", int'(in_ready), m_hold ? 0 : 1);
      chk("out_valid", int'(out_valid), m_hold ? 1 : 0);
      chk("acc_out", int'(acc_out), m_acc());
      chk("ovf", int'(ovf), m_ovf());
    end
    if (r || c) begin
      if (m_hold && exp_q.size() > 0) void'(exp_q.pop_back());
      m_blk.delete();
      m_hold = 1'b0;
    end else if (m_hold) begin
      if (ordy) begin
        m_blk.delete();
        m_hold = 1'b0;
      end
    end else if (v) begin
      m_blk.push_back(int'(s));
      if (m_blk.size() == BL) begin
        m_hold = 1'b1;
        e.acc = m_acc();
        e.ovf = (m_ovf() != 0);
        exp_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: every completed output handshake must match the oldest expected total.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (chk_en && out_valid && out_ready && !clr && !rst) begin
        if (exp_q.size() == 0) begin
          total_cnt++;
          bad_cnt++;
          $display("FAIL hs_unexpected: got total %0d expected no handshake", acc_out);
        end else begin
          e = exp_q.pop_front();
          chk("hs_acc", int'(acc_out), e.acc);
          chk("hs_ovf", int'(ovf), int'(e.ovf));
        end
      end
    end
  end

  initial begin
    in_valid = 1'b0; sum_in = '0; cout_in = 1'b0;
    out_ready = 1'b0; clr = 1'b0; rst = 1'b1;
    @(posedge clk);
    #1;
    step(1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    chk_en = 1'b1;
    chk("rst_acc", int'(acc_out), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 1);

    // Normal block: 10 + 25 + 1 + 3 = 39.
    step(1'b1, 5'd10, 1'b0, 1'b0, 1'b0);
    step(1'b1, 5'd25, 1'b0, 1'b0, 1'b0);
    step(1'b1, 5'd1,  1'b0, 1'b0, 1'b0);
    step(1'b1, 5'd3,  1'b0, 1'b0, 1'b0);
    chk("blk_acc", int'(acc_out), 39);
    chk("blk_valid", int'(out_valid), 1);
    chk("blk_ovf", int'(ovf), 0);
    chk("blk_in_ready", int'(in_ready), 0);

    // Backpressure: inputs ignored while the total waits.
    for (int i = 0; i < 5; i++) step(1'b1, SMP_W'($urandom), 1'b0, 1'b0, 1'b0);
    chk("bp_acc", int'(acc_out), 39);
    chk("bp_in_ready", int'(in_ready), 0);
    step(1'b1, SMP_W'($urandom), 1'b1, 1'b0, 1'b0);
    chk("bp_rel_valid", int'(out_valid), 0);
    chk("bp_rel_acc", int'(acc_out), 0);
    chk("bp_rel_in_ready", int'(in_ready), 1);

    // Saturation: 31, 62, 63 (clamped), 63.
    step(1'b1, 5'd31, 1'b0, 1'b0, 1'b0);
    step(1'b1, 5'd31, 1'b0, 1'b0, 1'b0);
    chk("sat2_acc", int'(acc_out), 62);
    chk("sat2_ovf", int'(ovf), 0);
    step(1'b1, 5'd31, 1'b0, 1'b0, 1'b0);
    chk("sat3_acc", int'(acc_out), 63);
    chk("sat3_ovf", int'(ovf), 1);
    step(1'b1, 5'd31, 1'b0, 1'b0, 1'b0);
    chk("sat4_acc", int'(acc_out), 63);
    chk("sat4_ovf", int'(ovf), 1);
    chk("sat4_valid", int'(out_valid), 1);
    step(1'b0, 5'd0, 1'b1, 1'b0, 1'b0);

    // Clear mid-block drops the clr-cycle sample.
    step(1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
    step(1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
    step(1'b1, 5'd7, 1'b0, 1'b1, 1'b0);
    chk("clr_acc", int'(acc_out), 0);
    chk("clr_in_ready", int'(in_ready), 1);
    for (int i = 0; i < 4; i++) step(1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    chk("clr_blk_valid", int'(out_valid), 1);
    chk("clr_blk_acc", int'(acc_out), 20);
    step(1'b0, 5'd0, 1'b1, 1'b0, 1'b0);

    // Reset while a total is held.
    for (int i = 0; i < 4; i++) step(1'b1, SMP_W'($urandom), 1'b0, 1'b0, 1'b0);
    chk("hold_valid", int'(out_valid), 1);
    step(1'b1, SMP_W'($urandom), 1'b0, 1'b0, 1'b1);
    chk("rsthold_valid", int'(out_valid), 0);
    chk("rsthold_in_ready", int'(in_ready), 1);
    chk("rsthold_acc", int'(acc_out), 0);
    chk("rsthold_ovf", int'(ovf), 0);

    // Random traffic with occasional clr and rst.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0), SMP_W'($urandom), ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 39) == 0), ($urandom_range(0, 99) == 0));
    end
    step(1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    chk("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
